sha_msg_ctrl: RTL

- Message sequencer for the single-block SHA-256 core. Accepts a byte stream from the UART receive path, buffers 64-byte blocks and applies SHA-256 padding and the 64-bit length field.
- Issues each block to the core and waits for core completion. Delivers the final 256-bit digest to the UART transmit path.
- Clears the core's chaining state before every message, because the core accumulates its h[] registers across blocks.

---
 rtl/sha_msg_ctrl.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/sha_msg_ctrl.sv
// Message sequencer for a single-block SHA-256 core: buffers input bytes into
// 64-byte blocks, appends SHA-256 padding and the bit length, and collects the digest.
module sha_msg_ctrl #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned LEN_W   = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  input  logic [7:0]   in_data,
  input  logic         in_last,
  output logic         in_ready,
  output logic         core_rst,
  output logic         core_start,
  output logic [511:0] core_block,
  input  logic         core_complete,
  input  logic [255:0] core_hash,
  output logic [255:0] hash_out,
  output logic         hash_valid,
  output logic         busy,
  output logic         error
);

  localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);
  localparam int unsigned IDX_W = 7;

  typedef enum logic [3:0] {
    S_IDLE, S_CLEAR, S_FILL, S_PAD80, S_ZERO, S_LEN, S_ISSUE, S_WAIT, S_DONE, S_ERR
  } state_t;

  state_t               state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [LEN_W-1:0]     len_q, len_d;
  logic                 last_q, last_d;
  logic                 final_q, final_d;
  logic                 extra_q, extra_d;
  logic [TMO_W-1:0]     tmo_q, tmo_d;
  logic [0:63][7:0]     blk_q, blk_d;
  logic [255:0]         hash_d;
  logic                 error_d, in_ready_d, core_rst_d, core_start_d, hash_valid_d, busy_d;
  logic [63:0]          bit_len;
  logic [2:0]           len_sel;
  logic [7:0]           len_byte;

  assign core_block = blk_q;

  // Big-endian byte of the 64-bit bit length for the current index 56..63
  assign bit_len  = 64'({len_q, 3'b000});
  assign len_sel  = 3'd7 - idx_q[2:0];
  assign len_byte = bit_len[{len_sel, 3'b000} +: 8];

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (in_valid) state_d = S_CLEAR;
      S_CLEAR: state_d = S_FILL;
      S_FILL: begin
        if (in_valid && in_ready) begin
          if (idx_q == IDX_W'(63)) state_d = S_ISSUE;
          else if (in_last)        state_d = S_PAD80;
        end
      end
      // Short-cut to LEN/ISSUE when the 0x80 lands on the last byte before a boundary
      S_PAD80: begin
        if (idx_q == IDX_W'(55))      state_d = S_LEN;
        else if (idx_q == IDX_W'(63)) state_d = S_ISSUE;
        else                          state_d = S_ZERO;
      end
      S_ZERO: begin
        if (!extra_q && idx_q == IDX_W'(55))     state_d = S_LEN;
        else if (extra_q && idx_q == IDX_W'(63)) state_d = S_ISSUE;
      end
      S_LEN:   if (idx_q == IDX_W'(63)) state_d = S_ISSUE;
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        if (core_complete) begin
          if (final_q)      state_d = S_DONE;
          else if (extra_q) state_d = S_ZERO;
          else if (last_q)  state_d = S_PAD80;
          else              state_d = S_FILL;
        end else if (tmo_q == TMO_W'(TIMEOUT)) begin
          state_d = S_ERR;
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    idx_d   = idx_q;
    len_d   = len_q;
    last_d  = last_q;
    final_d = final_q;
    extra_d = extra_q;
    tmo_d   = tmo_q;
    blk_d   = blk_q;
    hash_d  = hash_out;
    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        idx_d   = '0;
        len_d   = '0;
        last_d  = 1'b0;
        final_d = 1'b0;
        extra_d = 1'b0;
      end
      S_FILL: begin
        if (in_valid && in_ready) begin
          blk_d[idx_q[5:0]] = in_data;
          idx_d = idx_q + IDX_W'(1);
          len_d = len_q + LEN_W'(1);
          if (in_last) last_d = 1'b1;
        end
      end
      S_PAD80: begin
        blk_d[idx_q[5:0]] = 8'h80;
        idx_d   = idx_q + IDX_W'(1);
        extra_d = (idx_q >= IDX_W'(56));
      end
      S_ZERO: begin
        blk_d[idx_q[5:0]] = 8'h00;
        idx_d = idx_q + IDX_W'(1);
      end
      S_LEN: begin
        blk_d[idx_q[5:0]] = len_byte;
        idx_d = idx_q + IDX_W'(1);
        if (idx_q == IDX_W'(63)) final_d = 1'b1;
      end
      S_ISSUE: tmo_d = '0;
      S_WAIT: begin
        if (core_complete) begin
          if (final_q) begin
            hash_d = core_hash;
          end else begin
            idx_d   = '0;
            extra_d = 1'b0;
          end
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      default: ;
    endcase

    // Outputs are registered against the next state so they line up with it
    in_ready_d   = (state_d == S_FILL);
    core_rst_d   = (state_d == S_CLEAR);
    core_start_d = (state_d == S_ISSUE);
    hash_valid_d = (state_d == S_DONE);
    busy_d       = (state_d != S_IDLE) && (state_d != S_ERR);
    error_d      = error || (state_d == S_ERR);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      idx_q      <= '0;
      len_q      <= '0;
      last_q     <= 1'b0;
      final_q    <= 1'b0;
      extra_q    <= 1'b0;
      tmo_q      <= '0;
      blk_q      <= '0;
      hash_out   <= '0;
      error      <= 1'b0;
      in_ready   <= 1'b0;
      core_rst   <= 1'b0;
      core_start <= 1'b0;
      hash_valid <= 1'b0;
      busy       <= 1'b0;
    end else begin
      idx_q      <= idx_d;
      len_q      <= len_d;
      last_q     <= last_d;
      final_q    <= final_d;
      extra_q    <= extra_d;
      tmo_q      <= tmo_d;
      blk_q      <= blk_d;
      hash_out   <= hash_d;
      error      <= error_d;
      in_ready   <= in_ready_d;
      core_rst   <= core_rst_d;
      core_start <= core_start_d;
      hash_valid <= hash_valid_d;
      busy       <= busy_d;
    end
  end

endmodule
